// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the ID-stage decoder and the hazard scoreboard.
// The decoder (master) presents the instruction being issued; the scoreboard
// (slave) answers with the hold/bubble controls and its status outputs.
interface hazard_scoreboard_if #(
    parameter int STAT_W = 16
);
    logic              issue_valid;
    logic [4:0]        issue_rs;
    logic [4:0]        issue_rt;
    logic              use_rs;
    logic              use_rt;
    logic              issue_wr;
    logic [4:0]        issue_rd;
    logic [2:0]        issue_lat;
    logic              flush;
    logic              stall;
    logic              pc_hold;
    logic              ifid_hold;
    logic              idex_bubble;
    logic [31:0]       pending_mask;
    logic [STAT_W-1:0] stall_cycles;

    modport master (
        output issue_valid, issue_rs, issue_rt, use_rs, use_rt,
               issue_wr, issue_rd, issue_lat, flush,
        input  stall, pc_hold, ifid_hold, idex_bubble, pending_mask, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, use_rs, use_rt,
               issue_wr, issue_rd, issue_lat, flush,
        output stall, pc_hold, ifid_hold, idex_bubble, pending_mask, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard. Each architectural register r (1..31) owns a
// small down-counter holding the number of cycles left before its in-flight
// result becomes forwardable. An issuing instruction stalls while any source
// it reads is still counting (RAW), or while an older write to its destination
// would finish later than the new one (WAW). Register 0 never has a counter.
module hazard_scoreboard #(
    parameter int MAX_LAT = 7,
    parameter int STAT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   bus
);
    localparam int CW = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Per-register remaining-latency counters; register 0 is excluded.
    logic [CW-1:0] cnt [1:31];

    // Read view of the counters with register 0 tied to "ready".
    logic [CW-1:0] cntView [0:31];

    logic [CW-1:0] latC;
    logic          rawA;
    logic          rawB;
    logic          waw;
    logic          stallInt;
    logic          acc;
    logic [31:1]   writeHit;
    logic [31:0]   pendingMask;
    logic [STAT_W-1:0] statCount;

    // Build the read view so index 0 always looks ready.
    always_comb begin
        cntView[0] = '0;
        for (int r = 1; r < 32; r++) begin
            cntView[r] = cnt[r];
        end
    end

    // Clamp the requested latency to the largest value a counter can hold.
    always_comb begin
        if (int'(bus.issue_lat) > MAX_LAT) begin
            latC = CW'(MAX_LAT);
        end else begin
            latC = CW'(bus.issue_lat);
        end
    end

    // Hazard detection and stall/accept decision for the ID-stage instruction.
    always_comb begin
        rawA     = bus.use_rs && (bus.issue_rs != 5'd0) && (cntView[bus.issue_rs] != '0);
        rawB     = bus.use_rt && (bus.issue_rt != 5'd0) && (cntView[bus.issue_rt] != '0);
        waw      = bus.issue_wr && (bus.issue_rd != 5'd0) && (cntView[bus.issue_rd] > latC);
        stallInt = bus.issue_valid && !bus.flush && (rawA || rawB || waw);
        acc      = bus.issue_valid && !bus.flush && !stallInt;
    end

    // One-hot select of the counter that an accepted writer loads.
    always_comb begin
        writeHit = '0;
        for (int r = 1; r < 32; r++) begin
            writeHit[r] = acc && bus.issue_wr && (bus.issue_rd == 5'(r));
        end
    end

    // Counter update: a fresh issue overrides the decrement of the same slot.
    always_ff @(posedge clk) begin
        for (int r = 1; r < 32; r++) begin
            if (rst) begin
                cnt[r] <= '0;
            end else if (writeHit[r]) begin
                cnt[r] <= latC;
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

    // Pending mask mirrors which registers are still counting down.
    always_comb begin
        pendingMask = '0;
        for (int r = 1; r < 32; r++) begin
            pendingMask[r] = (cnt[r] != '0);
        end
    end

    // Saturating statistics counter of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            statCount <= '0;
        end else if (stallInt && (statCount != STAT_MAX)) begin
            statCount <= statCount + STAT_ONE;
        end
    end

    // Drive the pipeline controls; flush alone still forces a bubble.
    always_comb begin
        bus.stall        = stallInt;
        bus.pc_hold      = stallInt;
        bus.ifid_hold    = stallInt;
        bus.idex_bubble  = stallInt || bus.flush;
        bus.pending_mask = pendingMask;
        bus.stall_cycles = statCount;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side complement to the EX-stage forwarding unit. Sits in the ID stage and tracks destination registers written by in-flight instructions.
- Tracks how many cycles remain until each result can be forwarded. Stalls the consuming instruction until the result is forwardable.
- Covers load-use hazards and multi-cycle units such as mult/div.
- Drives PC hold, IF/ID hold and ID/EX bubble insertion.

Parameters:
- MAX_LAT, 7, largest issue latency tracked; counters are $clog2(MAX_LAT+1) bits wide.
- STAT_W, 16, width of the saturating stall-cycle statistics counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- issue_valid  input  1  ID-stage instruction is valid
- issue_rs  input  5  source register A
- issue_rt  input  5  source register B
- use_rs  input  1  instruction reads rs
- use_rt  input  1  instruction reads rt
- issue_wr  input  1  instruction writes a register (regWrite)
- issue_rd  input  5  destination register
- issue_lat  input  3  cycles after issue before result is forwardable (ALU 0, load 1, mult/div up to MAX_LAT)
- flush  input  1  branch/jump squash of the ID-stage instruction
- stall  output  1  combinational; ID-stage instruction must wait
- pc_hold  output  1  equals stall
- ifid_hold  output  1  equals stall
- idex_bubble  output  1  stall OR flush; ID/EX loads a NOP
- pending_mask  output  32  bit r = 1 when cnt[r] != 0; bit 0 is always 0
- stall_cycles  output  STAT_W  saturating count of stalled cycles

Behaviour:
- State: cnt[1..31], each $clog2(MAX_LAT+1) bits. cnt[r] is the number of cycles remaining before register r is forwardable. 0 means ready, either from a forwarding path or from the register file. Register 0 has no counter and always reads 0.
- Read hazard (RAW):
  - raw_a = use_rs & (issue_rs != 0) & (cnt[issue_rs] != 0)
  - raw_b is the same expression using rt.
- WAW hazard:
  - waw = issue_wr & (issue_rd != 0) & (cnt[issue_rd] > lat_c)
  - lat_c = min(issue_lat, MAX_LAT)
  - An older long-latency write must not complete after a younger one.
- stall = issue_valid & ~flush & (raw_a | raw_b | waw). It is purely combinational, with no added latency.
- Accept: acc = issue_valid & ~flush & ~stall.
- Counter update on each rising edge, applied per register r:
  - if rst: cnt[r] <= 0
  - else if acc & issue_wr & issue_rd == r & r != 0: cnt[r] <= lat_c. The new issue wins over the decrement.
  - else if cnt[r] != 0: cnt[r] <= cnt[r] - 1
  - else: hold 0
- Timing:
  - A load accepted at cycle t with lat 1 gives cnt = 1 at t+1.
  - A dependent instruction stalls at t+1 and proceeds at t+2, exactly one bubble.
  - An ALU producer with lat 0 never stalls a consumer; the forwarding unit covers it.
  - With lat L, a dependent instruction issued right behind the producer stalls exactly L cycles.
- Flush:
  - Suppresses stall and accept for the current cycle, and asserts idex_bubble.
  - Does not clear existing counters, because older in-flight instructions still complete.
- issue_lat > MAX_LAT is clamped to MAX_LAT.
- issue_wr with rd = 0 is accepted but records nothing.
- rs == rt == hazard register: single stall, same timing as one source.
- stall_cycles:
  - Increments by 1 on each edge where stall = 1.
  - Holds at all-ones and never wraps.
  - Reset to 0.
- Reset values: all cnt = 0; stall, pc_hold, ifid_hold, idex_bubble = 0 (given idle inputs); pending_mask = 0; stall_cycles = 0.
- Reset asserted mid-stall: on the next edge all counters clear, and stall deasserts in that cycle if rst is held and inputs are unchanged.
- While stalled, the held instruction re-presents the same inputs each cycle. It must not be recorded until stall drops.

Test Plan:
- Load-use: issue lw rd=5 lat 1, next cycle add rs=5 -> stall=1 for 1 cycle, idex_bubble=1 for that cycle, add accepted the following cycle, stall_cycles=1.
- ALU back-to-back: add rd=3 lat 0, then sub rs=3 rt=3 -> stall never asserts, pending_mask stays 0.
- Multi-cycle plus WAW:
  - mult rd=8 lat 5, then immediately add rs=8 -> stall for exactly 5 cycles.
  - Separately, mult rd=8 lat 5, then addi rd=8 lat 0 with no reads -> stall until cnt[8]=0, i.e. 5 cycles.
- Register zero: lw rd=0 lat 1, then add rs=0 rt=0 -> no stall, pending_mask=0.
- Flush:
  - Issue lw rd=9 with flush=1 -> idex_bubble=1, cnt[9] stays 0, no later stall on rs=9.
  - Flush while a stall condition exists -> stall=0.
- Reset/saturation:
  - Assert rst during a 5-cycle mult stall -> next edge pending_mask=0, stall_cycles=0.
  - Force STAT_W=4 and stall 20 cycles -> stall_cycles holds at 15.
